// File: rtl/bit_serializer.sv
// Parallel-to-serial converter, MSB of the valid field first.
// A one-entry holding buffer sits in front of a DATA_W shift register so the
// next word can be queued while the current one is shifting out.
//
// Handshake: in_ready is a registered signal. A word transfers on a rising
// edge where in_valid=1 and in_ready=1. in_ready depends only on buffer
// state, never on in_valid. On the output side, out_valid marks a bit as
// emitted this cycle. stall=1 freezes the shifter, counter and FSM, so out_bit
// holds its value. The buffer can still accept a word while stalled.
module bit_serializer #(
  parameter int DATA_W = 8,
  parameter int LEN_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_data,
  input  logic [LEN_W-1:0]  in_len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              stall,
  output logic              out_bit,
  output logic              out_valid,
  output logic              out_first,
  output logic              out_last,
  output logic [15:0]       words_done,
  output logic              dbg_state
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(DATA_W);

  logic [0:0]        state_q, state_d;
  logic              buf_full_q, buf_full_d;
  logic [DATA_W-1:0] buf_data_q, buf_data_d;
  logic [LEN_W-1:0]  buf_len_q, buf_len_d;
  logic [DATA_W-1:0] sh_q, sh_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic              first_q, first_d;
  logic [15:0]       words_done_q, words_done_d;

  logic              accept;
  logic              shifting;
  logic              last_edge;
  logic              load;
  logic [LEN_W-1:0]  len_clamped;
  logic [LEN_W-1:0]  shamt;

  // Next-state logic for buffer, shifter, counter, FSM and word counter.
  always_comb begin
    accept      = in_valid && !buf_full_q;
    len_clamped = ((in_len == '0) || (in_len > LEN_MAX)) ? LEN_MAX : in_len;
    shifting    = (state_q == ST_SHIFT) && !stall;
    last_edge   = shifting && (cnt_q == LEN_W'(1));
    // A buffered word moves into the shifter either from IDLE or directly on
    // the last bit of the previous word, which keeps len>=2 words gapless.
    load        = !stall && buf_full_q && ((state_q == ST_IDLE) || last_edge);
    // Left-align the valid field so its top bit lands on the shifter MSB.
    shamt       = LEN_MAX - buf_len_q;

    state_d      = state_q;
    buf_full_d   = buf_full_q;
    buf_data_d   = buf_data_q;
    buf_len_d    = buf_len_q;
    sh_d         = sh_q;
    cnt_d        = cnt_q;
    first_d      = first_q;
    words_done_d = words_done_q + (last_edge ? 16'd1 : 16'd0);

    // Accept and load never coincide: load needs a full buffer, accept an empty one.
    if (accept) begin
      buf_full_d = 1'b1;
      buf_data_d = in_data;
      buf_len_d  = len_clamped;
    end

    if (load) begin
      buf_full_d = 1'b0;
      sh_d       = buf_data_q << shamt;
      cnt_d      = buf_len_q;
      first_d    = 1'b1;
      state_d    = ST_SHIFT;
    end else if (shifting) begin
      sh_d    = sh_q << 1;
      cnt_d   = cnt_q - LEN_W'(1);
      first_d = 1'b0;
      if (last_edge) begin
        state_d = ST_IDLE;
      end
    end
  end

  // State registers; synchronous reset wins over accept, load and shift.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      buf_full_q   <= 1'b0;
      buf_data_q   <= '0;
      buf_len_q    <= '0;
      sh_q         <= '0;
      cnt_q        <= '0;
      first_q      <= 1'b0;
      words_done_q <= 16'd0;
    end else begin
      state_q      <= state_d;
      buf_full_q   <= buf_full_d;
      buf_data_q   <= buf_data_d;
      buf_len_q    <= buf_len_d;
      sh_q         <= sh_d;
      cnt_q        <= cnt_d;
      first_q      <= first_d;
      words_done_q <= words_done_d;
    end
  end

  // Outputs are decoded from registered state plus the stall qualifier.
  always_comb begin
    in_ready   = !buf_full_q;
    out_valid  = shifting;
    out_bit    = sh_q[DATA_W-1];
    out_first  = first_q && shifting;
    out_last   = last_edge;
    words_done = words_done_q;
    dbg_state  = state_q[0];
  end

endmodule

// File: tb/tb_bit_serializer.sv
// Directed testbench for bit_serializer: table of single words plus
// hand-written multi-cycle sequences (back-to-back, stall, len=1 gap,
// reset mid-word, words_done wrap).
module tb_bit_serializer;

  logic        clk;
  logic        reset;
  logic [7:0]  in_data;
  logic [3:0]  in_len;
  logic        in_valid;
  logic        in_ready;
  logic        stall;
  logic        out_bit;
  logic        out_valid;
  logic        out_first;
  logic        out_last;
  logic [15:0] words_done;
  logic        dbg_state;

  int checks   = 0;
  int failures = 0;
  int rises    = 0;
  logic prev_valid = 1'b0;
  logic [15:0] exp_done = 16'd0;

  // expected emitted bit as {bit, first, last}
  logic [2:0] exp_q[$];

  typedef struct {
    logic [7:0]  data;
    logic [3:0]  len;
    logic [15:0] exp_bits;
    int          exp_n;
  } vec_t;

  vec_t vecs[9];

  bit_serializer #(.DATA_W(8), .LEN_W(4)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_len(in_len),
    .in_valid(in_valid), .in_ready(in_ready), .stall(stall),
    .out_bit(out_bit), .out_valid(out_valid), .out_first(out_first),
    .out_last(out_last), .words_done(words_done), .dbg_state(dbg_state)
  );

  // clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // scoreboard: every emitted bit must match the head of exp_q
  always @(negedge clk) begin
    if (out_valid && !prev_valid) rises++;
    prev_valid = out_valid;
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_bit: got bit=%0b first=%0b last=%0b expected none",
                 out_bit, out_first, out_last);
      end else begin
        chk("serial_bit{bit,first,last}", {29'd0, out_bit, out_first, out_last},
            {29'd0, exp_q.pop_front()});
      end
    end
  end

  // driver tasks
  task automatic push_word(input logic [15:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({bits[n-1-i], (i == 0), (i == n-1)});
    end
  endtask

  task automatic send(input logic [7:0] d, input logic [3:0] l);
    int t;
    t = 0;
    in_data  = d;
    in_len   = l;
    in_valid = 1'b1;
    while (!in_ready && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: in_ready=0 expected 1 within 200 cycles");
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input int max_cyc);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < max_cyc) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout: %0d bits pending expected 0", exp_q.size());
      exp_q.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int rb;
    vecs[0] = '{8'h0B, 4'd4,  16'b1011,     4};
    vecs[1] = '{8'hFF, 4'd0,  16'b11111111, 8};
    vecs[2] = '{8'hA5, 4'd8,  16'b10100101, 8};
    vecs[3] = '{8'h55, 4'd9,  16'b01010101, 8};
    vecs[4] = '{8'h03, 4'd2,  16'b11,       2};
    vecs[5] = '{8'h01, 4'd1,  16'b1,        1};
    vecs[6] = '{8'h02, 4'd3,  16'b010,      3};
    vecs[7] = '{8'hF6, 4'd3,  16'b110,      3};
    vecs[8] = '{8'h80, 4'd15, 16'b10000000, 8};

    reset = 1'b1; in_data = 8'd0; in_len = 4'd0; in_valid = 1'b0; stall = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // reset state
    @(negedge clk);
    chk("reset_in_ready",   {31'd0, in_ready},  32'd1);
    chk("reset_out_valid",  {31'd0, out_valid}, 32'd0);
    chk("reset_out_first",  {31'd0, out_first}, 32'd0);
    chk("reset_out_last",   {31'd0, out_last},  32'd0);
    chk("reset_out_bit",    {31'd0, out_bit},   32'd0);
    chk("reset_words_done", {16'd0, words_done}, 32'd0);
    @(posedge clk); #1;

    // table: single words
    for (int v = 0; v < 9; v++) begin
      rb = rises;
      push_word(vecs[v].exp_bits, vecs[v].exp_n);
      send(vecs[v].data, vecs[v].len);
      wait_drain(100);
      exp_done++;
      chk($sformatf("vec%0d_words_done", v), {16'd0, words_done}, {16'd0, exp_done});
      chk($sformatf("vec%0d_contiguous", v), rises - rb, 32'd1);
      idle(2);
    end

    // back-to-back 0xA5/8 then 0x0B/4: 12 contiguous bits
    rb = rises;
    push_word(16'b10100101, 8);
    push_word(16'b1011, 4);
    send(8'hA5, 4'd8);
    send(8'h0B, 4'd4);
    wait_drain(100);
    exp_done += 2;
    chk("b2b_words_done", {16'd0, words_done}, {16'd0, exp_done});
    chk("b2b_contiguous", rises - rb, 32'd1);
    idle(2);

    // stall 3 cycles after bit 2 of 0x0B, queue 0x03/2 while stalled
    rb = rises;
    push_word(16'b1011, 4);
    push_word(16'b11, 2);
    send(8'h0B, 4'd4);
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    stall = 1'b1;
    in_data = 8'h03; in_len = 4'd2; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("stall%0d_out_valid", i), {31'd0, out_valid}, 32'd0);
      chk($sformatf("stall%0d_out_bit", i),   {31'd0, out_bit},   32'd1);
      if (i == 1) chk("stall_accept_in_ready", {31'd0, in_ready}, 32'd0);
      @(posedge clk); #1;
      if (i == 0) in_valid = 1'b0;
    end
    stall = 1'b0;
    wait_drain(100);
    exp_done += 2;
    chk("stall_words_done", {16'd0, words_done}, {16'd0, exp_done});
    chk("stall_segments", rises - rb, 32'd2);
    idle(2);

    // two len=1 words: one idle cycle between them
    rb = rises;
    push_word(16'b1, 1);
    push_word(16'b0, 1);
    send(8'h01, 4'd1);
    send(8'h00, 4'd1);
    wait_drain(100);
    exp_done += 2;
    chk("len1_words_done", {16'd0, words_done}, {16'd0, exp_done});
    chk("len1_gap_segments", rises - rb, 32'd2);
    idle(2);

    // reset after bit 2 of 0xA5 with 0x0F buffered
    push_word(16'b10, 2);
    exp_q[1] = 3'b000;  // bit 2 of an 8-bit word is not the last bit
    send(8'hA5, 4'd8);
    send(8'h0F, 4'd4);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_done = 16'd0;
    @(negedge clk);
    chk("rst_mid_out_valid",  {31'd0, out_valid}, 32'd0);
    chk("rst_mid_in_ready",   {31'd0, in_ready},  32'd1);
    chk("rst_mid_words_done", {16'd0, words_done}, 32'd0);
    repeat (20) @(negedge clk);
    chk("rst_mid_pending_bits", exp_q.size(), 32'd0);
    @(posedge clk); #1;

    // words_done wrap: preset counter to 0xFFFF, then emit one word
    force dut.words_done_q = 16'hFFFF;
    @(posedge clk); #1;
    release dut.words_done_q;
    @(posedge clk); #1;
    chk("wrap_preset", {16'd0, words_done}, 32'h0000FFFF);
    push_word(16'b10, 2);
    send(8'h02, 4'd2);
    wait_drain(100);
    chk("wrap_words_done", {16'd0, words_done}, 32'd0);
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
